mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port unified memory (instructions in words 0-255, data in words 256-511) between the instruction-fetch port and the load/store data port.
- Sequences each access as a fixed three-state transaction and drives the memory's address, write-enable and write-data.
- Registers read data and returns it to the granted requester with a one-cycle ack.
- Data port has priority; a burst limit prevents fetch starvation.

Parameters:
- MEM_WORDS, 512, memory depth in 32-bit words; byte limit is MEM_WORDS*4.
- MAX_D_BURST, 4, maximum consecutive data grants while a fetch is pending; range 1-15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  32  fetch byte address, stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  out  32  fetched word.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  load data; for stores, the value read back after the write.
- mem_addr  out  32  byte address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.
- err  out  1  sticky address error; present only with ADDR_CHECK_EN, see below.

Behaviour:
- States:
  - IDLE: no access in progress. If d_req and not starve, go to BUSY_D. Else if i_req, go to BUSY_I. Else if d_req, go to BUSY_D. Otherwise stay.
  - BUSY_I / BUSY_D: access in progress. Always go to DONE after one cycle.
  - DONE: ack cycle. Always go to IDLE.
- starve = i_req && (burst_cnt == MAX_D_BURST).
- Latency: request sampled at edge k puts the FSM in BUSY at k; memory write occurs at edge k+1; ack is high during the cycle k+1 to k+2. Minimum 3 cycles per access. A continuously held req is therefore re-granted every 3 cycles.
- Requester handshake:
  - Requester must drop or replace req at the edge where it sees ack.
  - A req still high in IDLE is treated as a new request.
  - Changing addr, wdata or we while req is high and before ack is illegal; the resulting behaviour is undefined.
- BUSY_I:
  - mem_addr = i_addr, mem_we = 0.
  - i_rdata is registered from mem_rdata at the exiting edge.
- BUSY_D:
  - mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
  - d_rdata is registered from mem_rdata.
- DONE: exactly one of i_ack or d_ack is high, matching the grant.
- mem_we is decoded from state (BUSY_D && d_we) and is never high outside BUSY_D.
- In IDLE and DONE: mem_addr holds its last value, mem_we = 0, mem_wdata = 0.
- burst_cnt (4 bits):
  - Increments on each BUSY_D entry while i_req is high, saturating at MAX_D_BURST.
  - Clears on each BUSY_I entry.
  - Clears on any arbitration in IDLE where i_req is low.
- Simultaneous i_req and d_req with burst_cnt < MAX_D_BURST: data wins.
- With burst_cnt == MAX_D_BURST: fetch wins and the counter clears.
- Reset values: state IDLE, i_ack = 0, d_ack = 0, i_rdata = 0, d_rdata = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0, burst_cnt = 0, err = 0.
- Reset asserted mid-transaction:
  - mem_we drops immediately (asynchronously), so no write completes.
  - The pending ack is lost; requesters re-issue after reset.

Optional Feature:
- Macro: MEM_ARB_ADDR_CHECK_EN.
- Defined:
  - An access with addr >= MEM_WORDS*4, or addr[1:0] != 0, still follows IDLE -> BUSY -> DONE and acks normally.
  - mem_we is forced to 0 and the rdata returned is 32'h0.
  - err is set and stays set until reset.
- Not defined: no range or alignment checking; the err port is absent; mem_addr passes through unchanged.

Decomposition:
- Shared include mem_arb_defs.vh:
  - State encodings: IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, DONE = 2'd3.
  - MEM_WORDS default.
  - Instruction/data region boundary, word 256.
- One sub-module, mem_arb_pick: combinational grant selection from i_req, d_req and burst_cnt, plus the next-counter logic.
- The top level holds the FSM, data registers and memory drive.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x10, memory word 4 = 0xDEADBEEF -> i_ack high in the third cycle with i_rdata = 0xDEADBEEF; mem_we never asserted.
- Store then load: d_req, d_we = 1, d_addr = 0x400, d_wdata = 0x12345678 -> mem_we high exactly one cycle, d_ack; then load from 0x400 -> d_rdata = 0x12345678.
- Contention: i_req and d_req both held high with MAX_D_BURST = 4 -> grant order D, D, D, D, I, D, ...; no cycle with both acks high.
- Reset mid-access: assert reset during BUSY_D of a store to 0x404 -> mem_we drops the same cycle, word 0x404 unchanged, no d_ack, all outputs at reset values.
- Idle gaps: i_req pulses with idle cycles between -> burst_cnt stays 0; each fetch latency is 3 cycles.
- With MEM_ARB_ADDR_CHECK_EN: store to 0x800 -> d_ack with d_rdata = 0, mem_we stays 0, err = 1 and remains 1 until reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the FSM state encoding, bus widths, the default memory depth, the
// instruction/data region boundary and the address-legality helper.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned MEM_WORDS_DEFAULT = 512;
  // First word of the data region; words below it hold instructions.
  localparam int unsigned DATA_REGION_WORD  = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  // Memory-side request payload, registered as one unit.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } mem_bus_t;

  // Word-aligned and inside the populated byte range.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       mem_words);
    return (addr < ADDR_W'(mem_words * 4)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data ports, plus the next value of
// the consecutive-data-grant counter. Only meaningful while the FSM is idle.
// Ports:
//   i_req, d_req  pending requests
//   burst_cnt     data grants issued while a fetch has been waiting
//   grant_i_c     fetch wins this arbitration
//   grant_d_c     data wins this arbitration
//   cnt_next_c    counter value after this arbitration
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             grant_i_c,
  output logic             grant_d_c,
  output logic [CNT_W-1:0] cnt_next_c
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_D_BURST);

  logic starve_c;

  // Data has priority until the waiting fetch has seen MAX_D_BURST data grants.
  always_comb begin
    grant_i_c  = 1'b0;
    grant_d_c  = 1'b0;
    cnt_next_c = burst_cnt;
    starve_c   = i_req && (burst_cnt == MAX_CNT);

    if (d_req && !starve_c) begin
      grant_d_c = 1'b1;
    end else if (i_req) begin
      grant_i_c = 1'b1;
    end else if (d_req) begin
      grant_d_c = 1'b1;
    end

    // The counter only tracks data grants made while a fetch is waiting.
    if (!i_req || grant_i_c) begin
      cnt_next_c = '0;
    end else if (grant_d_c && (burst_cnt != MAX_CNT)) begin
      cnt_next_c = burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single-port unified memory (instructions in words 0-255,
// data above). Each access runs IDLE -> BUSY_I/BUSY_D -> DONE; read data is
// registered on leaving BUSY and returned with a one-cycle ack in DONE.
// Optional build macro MEM_ARB_ADDR_CHECK_EN adds range/alignment checking
// and the sticky err output.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   i_req/i_addr         fetch request; i_ack/i_rdata fetch response
//   d_req/d_we/d_addr/
//   d_wdata              load/store request; d_ack/d_rdata response
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata  memory interface (combinational read data)
//   err                  sticky address error (MEM_ARB_ADDR_CHECK_EN only)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_ADDR_CHECK_EN
  ,
  output logic              err
`endif
);

  // Parameter sanity at elaboration.
  if (MAX_D_BURST < 1 || MAX_D_BURST > 15) begin : g_bad_burst
    $error("mem_arbiter: MAX_D_BURST must be in 1..15");
  end
  if (MEM_WORDS == 0 || MEM_WORDS > 32'h4000_0000) begin : g_bad_depth
    $error("mem_arbiter: MEM_WORDS out of range");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  mem_bus_t          bus_q, bus_d;
  logic              i_ack_d, d_ack_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;

  logic              grant_i_c, grant_d_c;
  logic [CNT_W-1:0]  pick_cnt_c;
  logic              d_addr_bad_c;
  logic              cur_addr_bad_c;

  mem_arb_pick #(
    .MAX_D_BURST(MAX_D_BURST)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .burst_cnt  (burst_cnt_q),
    .grant_i_c  (grant_i_c),
    .grant_d_c  (grant_d_c),
    .cnt_next_c (pick_cnt_c)
  );

`ifdef MEM_ARB_ADDR_CHECK_EN
  logic err_d;
  // New store address checked at grant so mem_we never rises for it;
  // the registered address is checked while the access is in BUSY.
  assign d_addr_bad_c   = !addr_legal(d_addr, MEM_WORDS);
  assign cur_addr_bad_c = !addr_legal(bus_q.addr, MEM_WORDS);
`else
  assign d_addr_bad_c   = 1'b0;
  assign cur_addr_bad_c = 1'b0;
`endif

  assign mem_addr  = bus_q.addr;
  assign mem_we    = bus_q.we;
  assign mem_wdata = bus_q.wdata;

  // Next state, memory drive and response values.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    bus_d       = '{addr: bus_q.addr, we: 1'b0, wdata: '0};
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
`ifdef MEM_ARB_ADDR_CHECK_EN
    err_d       = err;
`endif

    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = pick_cnt_c;
        if (grant_d_c) begin
          state_d = ST_BUSY_D;
          bus_d   = '{addr: d_addr, we: d_we && !d_addr_bad_c, wdata: d_wdata};
        end else if (grant_i_c) begin
          state_d    = ST_BUSY_I;
          bus_d.addr = i_addr;
        end
      end

      ST_BUSY_I: begin
        state_d   = ST_DONE;
        i_ack_d   = 1'b1;
        i_rdata_d = cur_addr_bad_c ? '0 : mem_rdata;
`ifdef MEM_ARB_ADDR_CHECK_EN
        err_d     = err | cur_addr_bad_c;
`endif
      end

      ST_BUSY_D: begin
        state_d = ST_DONE;
        d_ack_d = 1'b1;
        // mem_rdata still shows the pre-write word at the write edge, so a
        // store returns the value the word holds once the write lands.
        if (cur_addr_bad_c) begin
          d_rdata_d = '0;
        end else if (bus_q.we) begin
          d_rdata_d = bus_q.wdata;
        end else begin
          d_rdata_d = mem_rdata;
        end
`ifdef MEM_ARB_ADDR_CHECK_EN
        err_d     = err | cur_addr_bad_c;
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output and memory-drive registers; reset clears mem_we asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q   <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      bus_q   <= bus_d;
      i_ack   <= i_ack_d;
      d_ack   <= d_ack_d;
      i_rdata <= i_rdata_d;
      d_rdata <= d_rdata_d;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses against a small memory, with a
// transaction-level model checked every cycle and literal spot checks.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned MAXB   = 4;
  localparam logic [31:0] D_BASE = 32'(DATA_REGION_WORD * 4);

  localparam int unsigned PRE_N = 3;
  localparam int unsigned PRE_WORD [PRE_N] = '{4, 257, 8};
  localparam logic [31:0] PRE_DATA [PRE_N] = '{32'hDEADBEEF, 32'h55AA55AA, 32'h0BADF00D};

  logic        clk, reset;
  logic        i_req, i_ack, d_req, d_we, d_ack, mem_we;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_ADDR_CHECK_EN
  logic        err;
`endif

  mem_arbiter #(.MEM_WORDS(512), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_ADDR_CHECK_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: synchronous write, combinational read, backdoor preload port.
  logic [31:0] mem [0:511];
  logic        bd_we;
  logic [8:0]  bd_word;
  logic [31:0] bd_data;
  assign mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_word] <= bd_data;
    else if (mem_we) mem[mem_addr[10:2]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Event counters for spot checks.
  int we_cycles = 0;
  int dack_cnt  = 0;
  initial forever begin
    @(negedge clk);
    if (mem_we) we_cycles++;
    if (d_ack) dack_cnt++;
  end

  // Transaction model: a grant at edge k occupies the port for three cycles
  // (write cycle, ack cycle, idle cycle); next arbitration is at edge k+3.
  logic [31:0] ref_mem [0:511];
  bit          cur_active, cur_is_d, cur_we, cur_bad;
  logic [31:0] cur_addr, cur_wdata, cur_rdata;
  int          cur_age;
  int          dstreak;
  bit          exp_err;

  initial begin
    bit take_d, take_i, exp_we;
    for (int w = 0; w < 512; w++) ref_mem[w] = '0;
    for (int p = 0; p < PRE_N; p++) ref_mem[PRE_WORD[p]] = PRE_DATA[p];
    cur_active = 0; cur_age = 0; dstreak = 0; exp_err = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_active = 0; dstreak = 0; exp_err = 0;
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
`ifdef MEM_ARB_ADDR_CHECK_EN
        chk("rst_err", err, 0);
`endif
        continue;
      end
      if (cur_active && cur_age == 1 && cur_bad) exp_err = 1;
      chk("m_i_ack", i_ack, (cur_active && cur_age == 1 && !cur_is_d) ? 1 : 0);
      chk("m_d_ack", d_ack, (cur_active && cur_age == 1 && cur_is_d) ? 1 : 0);
      if (cur_active && cur_age == 1 && !cur_is_d) chk("m_i_rdata", i_rdata, cur_rdata);
      if (cur_active && cur_age == 1 && cur_is_d) chk("m_d_rdata", d_rdata, cur_rdata);
      exp_we = cur_active && cur_age == 0 && cur_is_d && cur_we && !cur_bad;
      chk("m_mem_we", mem_we, exp_we);
      if (cur_active && cur_age == 0) chk("m_mem_addr", mem_addr, cur_addr);
      if (exp_we) chk("m_mem_wdata", mem_wdata, cur_wdata);
      if (!(cur_active && cur_age == 0)) chk("m_idle_wdata", mem_wdata, 0);
`ifdef MEM_ARB_ADDR_CHECK_EN
      chk("m_err", err, exp_err);
`endif
      // The write edge has passed without reset: commit the store.
      if (cur_active && cur_age == 1 && cur_is_d && cur_we && !cur_bad)
        ref_mem[cur_addr[10:2]] = cur_wdata;
      // Arbitration for the coming edge.
      if (!cur_active || cur_age >= 2) begin
        cur_active = 0;
        take_d = d_req && !(i_req && dstreak == MAXB);
        take_i = !take_d && i_req;
        if (!i_req || take_i) dstreak = 0;
        else if (take_d && dstreak < MAXB) dstreak++;
        if (take_d || take_i) begin
          cur_active = 1; cur_age = -1; cur_is_d = take_d;
          cur_addr  = take_d ? d_addr : i_addr;
          cur_we    = take_d && d_we;
          cur_wdata = d_wdata;
`ifdef MEM_ARB_ADDR_CHECK_EN
          cur_bad = (cur_addr >= 32'd2048) || (cur_addr[1:0] != 2'b00);
`else
          cur_bad = 0;
`endif
          if (cur_bad) cur_rdata = '0;
          else if (cur_we) cur_rdata = cur_wdata;
          else cur_rdata = ref_mem[cur_addr[10:2]];
        end
      end
      if (cur_active) cur_age++;
    end
  end

  // One access: raise req, wait for ack (bounded), drop req after the ack cycle.
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1; i_addr = addr; end
    lat = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        lat = n; rd = is_d ? d_rdata : i_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (is_d) begin d_req = 0; d_we = 0; end
    else i_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_ack, we0, dk0;
    logic [31:0] rd;
    logic [5:0] order;
    reset = 1; bd_we = 0; bd_word = '0; bd_data = '0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    for (int p = 0; p < PRE_N; p++) begin
      @(posedge clk); #1;
      bd_we = 1; bd_word = 9'(PRE_WORD[p]); bd_data = PRE_DATA[p];
    end
    @(posedge clk); #1; bd_we = 0;
    @(negedge clk);
    chk("reset_i_rdata", i_rdata, 0);
    chk("reset_d_rdata", d_rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_we", mem_we, 0);
    @(posedge clk); #1; reset = 0;

    // Single fetch of word 4.
    we0 = we_cycles;
    access(0, 0, 32'h10, 0, lat, rd);
    chk("fetch_latency", 32'(lat), 3);
    chk("fetch_rdata", rd, 32'hDEADBEEF);
    chk("fetch_no_write", 32'(we_cycles - we0), 0);

    // Store then load at the start of the data region.
    we0 = we_cycles;
    access(1, 1, D_BASE, 32'h12345678, lat, rd);
    chk("store_latency", 32'(lat), 3);
    chk("store_we_cycles", 32'(we_cycles - we0), 1);
    access(1, 0, D_BASE, 0, lat, rd);
    chk("load_rdata", rd, 32'h12345678);
    chk("store_landed", mem[256], 32'h12345678);

    // Fetches separated by idle cycles.
    for (int k = 0; k < 3; k++) begin
      repeat (k + 2) @(posedge clk);
      access(0, 0, 32'h20, 0, lat, rd);
      chk("gap_latency", 32'(lat), 3);
      chk("gap_rdata", rd, 32'h0BADF00D);
    end

    // Contention: both held, data bursts of MAXB then one fetch.
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = D_BASE;
    n_ack = 0; order = '0;
    for (int c = 0; c < 60 && n_ack < 6; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        order = {order[4:0], d_ack};
        n_ack++;
      end
    end
    @(posedge clk); #1; i_req = 0; d_req = 0;
    chk("contention_acks", 32'(n_ack), 6);
    chk("contention_order", 32'(order), 32'b111101);

    // Reset during the busy cycle of a store.
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_addr = D_BASE + 32'h4; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    chk("we_before_reset", mem_we, 1);
    dk0 = dack_cnt;
    reset = 1; #1;
    chk("we_at_reset", mem_we, 0);
    chk("addr_at_reset", mem_addr, 0);
    chk("d_ack_at_reset", d_ack, 0);
    d_req = 0; d_we = 0;
    repeat (2) @(posedge clk); #1; reset = 0;
    repeat (4) @(posedge clk); #1;
    chk("reset_word_kept", mem[257], 32'h55AA55AA);
    chk("reset_no_ack", 32'(dack_cnt - dk0), 0);
    access(1, 0, D_BASE + 32'h4, 0, lat, rd);
    chk("post_reset_load", rd, 32'h55AA55AA);

`ifdef MEM_ARB_ADDR_CHECK_EN
    we0 = we_cycles;
    access(1, 1, 32'h800, 32'hA5A5A5A5, lat, rd);
    chk("bad_store_latency", 32'(lat), 3);
    chk("bad_store_rdata", rd, 0);
    chk("bad_store_no_we", 32'(we_cycles - we0), 0);
    chk("err_set", err, 1);
    access(0, 0, 32'h10, 0, lat, rd);
    chk("good_after_err", rd, 32'hDEADBEEF);
    chk("err_sticky", err, 1);
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    chk("err_cleared", err, 0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
